// File: rtl/quant_engine.sv
// JPEG block quantizer: divides a 64-coefficient block by table-driven, quality-scaled steps,
// LANES coefficients per cycle, with a one-block input buffer and a valid/ready output stage.
module quant_engine #(
    parameter int COEFF_W = 16,
    parameter int OUT_W   = 16,
    parameter int LANES   = 1,
    parameter bit ROUND   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [1:0]             mode,
    input  logic [7:0]             scale,
    input  logic [64*COEFF_W-1:0]  coeff_in,
    input  logic                   coeff_valid,
    output logic                   coeff_ready,
    input  logic                   tbl_we,
    input  logic [5:0]             tbl_addr,
    input  logic [7:0]             tbl_wdata,
    output logic [64*OUT_W-1:0]    quant_out,
    output logic                   quant_valid,
    input  logic                   quant_ready,
    output logic [6:0]             zero_count,
    output logic                   sat_flag,
    output logic                   done,
    output logic                   busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PROC = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam logic [1:0] MODE_LUMA   = 2'd0;
    localparam logic [1:0] MODE_CHROMA = 2'd1;
    localparam logic [1:0] MODE_CUSTOM = 2'd2;

    localparam logic [5:0]       LAST_IDX = 6'(64 - LANES);
    localparam logic [COEFF_W:0] POS_MAX  = (COEFF_W+1)'((64'd1 << (OUT_W-1)) - 64'd1);
    localparam logic [COEFF_W:0] NEG_MAG  = (COEFF_W+1)'(64'd1 << (OUT_W-1));

    localparam logic [7:0] LUMA [64] = '{
        8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
        8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
        8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
        8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
        8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
        8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
        8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
        8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
    };

    localparam logic [7:0] CHROMA [64] = '{
        8'd17, 8'd18, 8'd24, 8'd47, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd18, 8'd21, 8'd26, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd24, 8'd26, 8'd56, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd47, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99
    };

    function automatic logic [7:0] calc_step(input logic [7:0] base, input logic [7:0] scl);
        logic [16:0] prod;
        logic [10:0] scaled;
        prod   = 17'(base) * 17'(scl) + 17'd32;
        scaled = prod[16:6];
        if (scaled == '0)
            return 8'd1;
        else if (scaled > 11'd255)
            return 8'd255;
        else
            return scaled[7:0];
    endfunction

    // Returns {saturated, result}; magnitude is unsigned so the most negative input divides cleanly.
    function automatic logic [OUT_W:0] quantize(input logic [COEFF_W-1:0] c, input logic [7:0] step);
        logic               neg;
        logic [COEFF_W-1:0] mag;
        logic [COEFF_W:0]   num;
        logic [COEFF_W:0]   q;
        logic [OUT_W-1:0]   res;
        logic               sat;
        neg = c[COEFF_W-1];
        mag = neg ? (~c + COEFF_W'(1)) : c;
        num = {1'b0, mag} + (COEFF_W+1)'(ROUND ? {1'b0, step[7:1]} : 8'd0);
        q   = num / (COEFF_W+1)'(step);
        sat = 1'b0;
        if (neg) begin
            if (q > NEG_MAG) begin
                res = {1'b1, {(OUT_W-1){1'b0}}};
                sat = 1'b1;
            end else begin
                res = -q[OUT_W-1:0];
            end
        end else if (q > POS_MAX) begin
            res = POS_MAX[OUT_W-1:0];
            sat = 1'b1;
        end else begin
            res = q[OUT_W-1:0];
        end
        return {sat, res};
    endfunction

    logic [1:0]         state_q, state_d;
    logic [5:0]         idx_q, idx_d;
    logic [6:0]         zero_q, zero_d;
    logic               sat_q, sat_d;
    logic               in_full_q, in_full_d;
    logic [1:0]         mode_q, mode_d;
    logic [7:0]         scale_q, scale_d;

    logic [COEFF_W-1:0] in_q   [64];
    logic [COEFF_W-1:0] work_q [64];
    logic [OUT_W-1:0]   out_q  [64];
    logic [7:0]         custom_q [64];

    logic [OUT_W-1:0]   lane_res [LANES];
    logic [LANES-1:0]   lane_sat;
    logic [LANES-1:0]   lane_zero;
    logic [6:0]         zero_inc;

    logic load, start, step_en, handshake, tbl_wr;

    assign load      = coeff_valid && !in_full_q;
    assign start     = (state_q == S_IDLE) && in_full_q;
    assign step_en   = (state_q == S_PROC) && enable;
    assign handshake = (state_q == S_OUT) && quant_ready;
    assign tbl_wr    = tbl_we && !busy;

    assign coeff_ready = !in_full_q;
    assign quant_valid = (state_q == S_OUT);
    assign busy        = (state_q != S_IDLE);
    assign done        = handshake;
    assign zero_count  = zero_q;
    assign sat_flag    = sat_q;

    always_comb begin : lanes
        logic [5:0] pos;
        logic [7:0] base;
        logic [7:0] step;
        pos      = '0;
        base     = '0;
        step     = '0;
        zero_inc = '0;
        for (int l = 0; l < LANES; l++) begin
            pos = idx_q + 6'(l);
            case (mode_q)
                MODE_LUMA:   base = LUMA[pos];
                MODE_CHROMA: base = CHROMA[pos];
                MODE_CUSTOM: base = custom_q[pos];
                default:     base = 8'd1;
            endcase
            step = (mode_q == MODE_LUMA || mode_q == MODE_CHROMA || mode_q == MODE_CUSTOM)
                   ? calc_step(base, scale_q) : 8'd1;
            {lane_sat[l], lane_res[l]} = quantize(work_q[pos], step);
            lane_zero[l] = (lane_res[l] == '0);
            zero_inc     = zero_inc + 7'(lane_zero[l]);
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        zero_d    = zero_q;
        sat_d     = sat_q;
        in_full_d = in_full_q;
        mode_d    = mode_q;
        scale_d   = scale_q;
        case (state_q)
            S_IDLE: if (in_full_q) begin
                in_full_d = 1'b0;
                mode_d    = mode;
                scale_d   = scale;
                idx_d     = '0;
                zero_d    = '0;
                sat_d     = 1'b0;
                state_d   = S_PROC;
            end
            S_PROC: if (enable) begin
                idx_d  = idx_q + 6'(LANES);
                zero_d = zero_q + zero_inc;
                sat_d  = sat_q | (|lane_sat);
                if (idx_q == LAST_IDX) state_d = S_OUT;
            end
            S_OUT: if (quant_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (load) in_full_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            zero_q    <= '0;
            sat_q     <= 1'b0;
            in_full_q <= 1'b0;
            mode_q    <= '0;
            scale_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            zero_q    <= zero_d;
            sat_q     <= sat_d;
            in_full_q <= in_full_d;
            mode_q    <= mode_d;
            scale_q   <= scale_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                custom_q[i] <= 8'd1;
                out_q[i]    <= '0;
            end
        end else begin
            if (tbl_wr) custom_q[tbl_addr] <= (tbl_wdata == 8'd0) ? 8'd1 : tbl_wdata;
            if (step_en) begin
                for (int l = 0; l < LANES; l++) out_q[idx_q + 6'(l)] <= lane_res[l];
            end
        end
    end

    // NOTE: the coefficient buffers carry no reset; in_full_q and the FSM decide whether they hold data.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 64; i++) in_q[i] <= coeff_in[i*COEFF_W +: COEFF_W];
        end
        if (start) work_q <= in_q;
    end

    always_comb begin
        quant_out = '0;
        for (int i = 0; i < 64; i++) quant_out[i*OUT_W +: OUT_W] = out_q[i];
    end

endmodule

// File: doc/quant_engine.md
# quant_engine

Parametrised block quantizer sitting between the 8x8 DCT stage and the zig-zag/run-length encoder. It divides each coefficient of a 64-coefficient block by a per-position step. The step comes from the luma, chroma or a host-loaded custom table, scaled at runtime by a quality factor. Rounding is selectable, the output is saturated to a configurable width, and the input is double-buffered. The output uses a valid/ready handshake with backpressure and reports zero-count and saturation side-band per block.

## Interface
Parameters:
- COEFF_W, 16: signed input coefficient width.
- OUT_W, 16: signed output coefficient width, must be ≤ COEFF_W.
- LANES, 1: coefficients quantized per cycle; one of 1, 2, 4, 8.
- ROUND, 1: 1 = round half away from zero; 0 = truncate toward zero.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  0 stalls S_PROC; other states unaffected.
- mode  in  2  0 luma, 1 chroma, 2 custom, 3 bypass (step = 1).
- scale  in  8  quality factor; 64 = unity.
- coeff_in  in  64*COEFF_W  block; coefficient i at [i*COEFF_W +: COEFF_W].
- coeff_valid  in  1  block offered.
- coeff_ready  out  1  input buffer empty.
- tbl_we  in  1  custom-table write strobe.
- tbl_addr  in  6  custom-table index.
- tbl_wdata  in  8  custom step.
- quant_out  out  64*OUT_W  quantized block, same packing as coeff_in.
- quant_valid  out  1  block presented.
- quant_ready  in  1  consumer accepts.
- zero_count  out  7  number of zero outputs in the presented block (0..64).
- sat_flag  out  1  ≥1 coefficient of the presented block clamped.
- done  out  1  one-cycle pulse on output handshake.
- busy  out  1  high in S_PROC and S_OUT.

## Operation
- Input buffer: a load occurs on coeff_valid && coeff_ready. The load copies coeff_in and sets in_full. coeff_ready = !in_full.
- FSM states: S_IDLE, S_PROC, S_OUT.
- S_IDLE with in_full:
  - Move the input buffer to the working buffer and clear in_full.
  - Latch mode and scale for the block.
  - Clear index, zero accumulator and sat accumulator.
  - Go to S_PROC.
- S_PROC: each enabled cycle processes LANES coefficients at index idx..idx+LANES-1. After 64/LANES enabled cycles, go to S_OUT.
- S_OUT: quant_valid=1. quant_out, zero_count and sat_flag are held stable until quant_ready. On the handshake: done pulse, then go to S_IDLE.
- Step computation:
  - base = table[i] (bypass: base=1, scaling skipped).
  - step = (base*scale + 32) >> 6, clamped to [1,255].
- Quantization:
  - m = |c|; q = (m + (ROUND ? step>>1 : 0)) / step.
  - Result = sign(c)·q, clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Any clamp sets the block sat accumulator.
  - c = -2^(COEFF_W-1) uses m = 2^(COEFF_W-1) (unsigned).
- Luma and chroma tables are the standard JPEG Annex K tables in row-major order: luma[0]=16, luma[1]=11, chroma[0]=17, chroma[4..63] mostly 99.
- Custom table:
  - Resets to all 1.
  - A write while busy=0 updates table[tbl_addr]; a tbl_wdata of 0 is stored as 1.
  - Writes while busy=1 are ignored.
- Double buffering: a new block may load during S_PROC or S_OUT. It is consumed the cycle after the return to S_IDLE.

## Timing
- Reset (rst_n low at a clk edge): state S_IDLE, in_full=0, custom table = 1.
  - Output reset values: quant_out=0, quant_valid=0, zero_count=0, sat_flag=0, done=0, busy=0, coeff_ready=1.
- A reset asserted mid-S_PROC or mid-S_OUT discards both buffers. No done pulse is produced.
- Load at edge k: S_PROC starts at k+1 (if S_IDLE). quant_valid rises at edge k+1+64/LANES with enable held high. Back-to-back throughput is one block per 64/LANES+2 cycles with quant_ready high.
- quant_valid and quant_out never change while quant_valid=1 && quant_ready=0.
- enable low in S_PROC freezes idx and accumulators. Loads and output handshakes still proceed.
- mode and scale changes mid-block have no effect until the next block is latched.

## Test plan
- Luma mode, scale=64, ROUND=1, coeff[0]=-1000, coeff[1]=50, rest 0 → out[0]=-63, out[1]=5, zero_count=62, sat_flag=0, quant_valid 65 cycles after load (LANES=1).
- Same block with ROUND=0 → out[0]=-62, out[1]=4. Chroma mode, coeff[0]=100 → out[0]=6.
- Scale tests, luma, coeff[0]=1000:
  - scale=128 → step 32, out[0]=31.
  - scale=0 → step clamped to 1, out[0]=1000.
- Saturation: OUT_W=8, bypass mode, coeff[5]=16000, coeff[6]=-16000 → out[5]=127, out[6]=-128, sat_flag=1.
- Custom table: write addr 3 = 0 then addr 4 = 10 while idle; mode 2, coeff[3]=7, coeff[4]=-25 → out[3]=7, out[4]=-3. A write during busy leaves the value unchanged.
- Backpressure and reset:
  - Hold quant_ready=0 for 20 cycles with a second block offered: output stays stable, the second block loads, and coeff_ready=0 for a third block.
  - Release quant_ready: done pulses, and the second block enters S_PROC one cycle later.
  - Reset at S_PROC idx=30: all outputs return to reset values and coeff_ready=1.
